// File: rtl/bus_if_arb_pkg.sv
// Shared bus encodings: command/response codes, arbiter state, bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Imported by Bus_if, bus_if_arb and the tag FIFO. Optional feature macro
// used by the arbiter: BUS_IF_ARB_FIXED_PRIO_EN.
package bus_if_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  // Master command encoding
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2
  } cmd_e;

  // Slave response encoding
  typedef enum logic [1:0] {
    NULL = 2'd0,
    DVA  = 2'd1,
    ERR  = 2'd3
  } resp_e;

  // Arbiter state: free to pick, or locked onto the port whose command is
  // on the bus but not yet accepted.
  typedef enum logic [1:0] {
    ARB_FREE   = 2'd0,
    ARB_HOLD_0 = 2'd1,
    ARB_HOLD_1 = 2'd2
  } Arb_state;

  function automatic logic is_req(input cmd_e cmd);
    return cmd != IDLE;
  endfunction

endpackage

// File: rtl/bus_if_arb_if.sv
// Request/response bus bundle between a master and a slave.
// Latency: n/a (wires only).
// Backpressure: SCmdAccept/SDataAccept on requests, MRespAccept on responses.
//
// Modports:
//   master - drives MCmd/MAddr/MData/MDataValid/MByteEn/MRespAccept/MReset_n
//   slave  - drives SCmdAccept/SDataAccept/SResp/SData
interface Bus_if;
  import bus_if_arb_pkg::*;

  cmd_e              MCmd;
  logic [ADDR_W-1:0] MAddr;
  logic [DATA_W-1:0] MData;
  logic              MDataValid;
  logic [BE_W-1:0]   MByteEn;
  logic              SCmdAccept;
  logic              SDataAccept;
  resp_e             SResp;
  logic [DATA_W-1:0] SData;
  logic              MRespAccept;
  logic              MReset_n;

  modport master (
    output MCmd, MAddr, MData, MDataValid, MByteEn, MRespAccept, MReset_n,
    input  SCmdAccept, SDataAccept, SResp, SData
  );

  // Reset travels with the shared clock domain, so the slave side does not
  // consume MReset_n from the bundle.
  modport slave (
    input  MCmd, MAddr, MData, MDataValid, MByteEn, MRespAccept,
    output SCmdAccept, SDataAccept, SResp, SData
  );

endinterface

// File: rtl/bus_if_arb_tag_fifo.sv
// Generic small FIFO holding the port tag of each accepted command.
// Latency: data_out shows the head combinationally; push/pop update on the next clock.
// Backpressure: push ignored while full, pop ignored while empty; full clears the cycle after a pop.
//
// Ports: clk, rst_n (async active-low), push/data_in, pop/data_out, full, empty.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module bus_if_arb_tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign data_out = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: rtl/bus_if_arb.sv
// Two-master to one-slave bus arbiter with in-order response return.
// Latency: zero added cycles on both the request and the response path.
// Backpressure: slave SCmdAccept=0 locks the grant on the requester; a full tag FIFO blocks all grants.
//
// Ports: Clk, MReset_n (async active-low, forwarded to out.MReset_n),
//        in_0/in_1 (Bus_if.slave, master ports), out (Bus_if.master, to slave).
// Macro BUS_IF_ARB_FIXED_PRIO_EN: ties always go to in_0, no round-robin state.
// NUM_IN_FLIGHT must be a power of two, at least 2.
module bus_if_arb
  import bus_if_arb_pkg::*;
#(
  parameter int NUM_IN_FLIGHT = 4
) (
  input  logic  Clk,
  input  logic  MReset_n,
  Bus_if.slave  in_0,
  Bus_if.slave  in_1,
  Bus_if.master out
);

  Arb_state state_q, state_d;

  logic req_0, req_1;
  logic gnt_vld;   // a command is presented on out this cycle
  logic gnt_idx;   // which port owns out
  logic cmd_acc;   // presented command accepted by the slave
  logic prio_1;    // tie goes to in_1 when set

  logic fifo_full, fifo_empty;
  logic head_tag;
  logic resp_acc;
  logic tag_pop;

  assign req_0 = is_req(in_0.MCmd);
  assign req_1 = is_req(in_1.MCmd);

  // ---------------------------------------------------------------------------
  // Tie-break priority
  // ---------------------------------------------------------------------------
`ifdef BUS_IF_ARB_FIXED_PRIO_EN
  assign prio_1 = 1'b0;
`else
  logic rr_q, rr_d;

  // Favour the port that did not win the most recent accepted command.
  always_comb begin
    rr_d = rr_q;
    if (cmd_acc) rr_d = ~gnt_idx;
  end

  always_ff @(posedge Clk or negedge MReset_n) begin
    if (!MReset_n) rr_q <= 1'b0;
    else           rr_q <= rr_d;
  end

  assign prio_1 = rr_q;
`endif

  // ---------------------------------------------------------------------------
  // Arbiter FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge MReset_n) begin
    if (!MReset_n) state_q <= ARB_FREE;
    else           state_q <= state_d;
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    state_d = state_q;

    case (state_q)
      ARB_HOLD_0: begin
        gnt_idx = 1'b0;
        gnt_vld = req_0;
      end
      ARB_HOLD_1: begin
        gnt_idx = 1'b1;
        gnt_vld = req_1;
      end
      default: begin
        gnt_idx = (req_0 && req_1) ? prio_1 : req_1;
        gnt_vld = req_0 || req_1;
      end
    endcase

    // Nothing goes out while the tag FIFO cannot record it, or during reset.
    // The state is left untouched so a hold survives the full condition.
    if (fifo_full || !MReset_n) gnt_vld = 1'b0;

    cmd_acc = gnt_vld && out.SCmdAccept;

    if (cmd_acc) begin
      state_d = ARB_FREE;
    end else if (gnt_vld) begin
      state_d = gnt_idx ? ARB_HOLD_1 : ARB_HOLD_0;
    end
  end

  // ---------------------------------------------------------------------------
  // Request path (combinational mux)
  // ---------------------------------------------------------------------------
  assign out.MReset_n   = MReset_n;
  assign out.MCmd       = !gnt_vld ? IDLE : (gnt_idx ? in_1.MCmd : in_0.MCmd);
  assign out.MAddr      = gnt_idx ? in_1.MAddr      : in_0.MAddr;
  assign out.MData      = gnt_idx ? in_1.MData      : in_0.MData;
  assign out.MDataValid = gnt_idx ? in_1.MDataValid : in_0.MDataValid;
  assign out.MByteEn    = gnt_idx ? in_1.MByteEn    : in_0.MByteEn;

  assign in_0.SCmdAccept  = gnt_vld && !gnt_idx && out.SCmdAccept;
  assign in_1.SCmdAccept  = gnt_vld &&  gnt_idx && out.SCmdAccept;
  assign in_0.SDataAccept = gnt_vld && !gnt_idx && out.SDataAccept;
  assign in_1.SDataAccept = gnt_vld &&  gnt_idx && out.SDataAccept;

  // ---------------------------------------------------------------------------
  // Response path: head tag steers the response back to its originator
  // ---------------------------------------------------------------------------
  assign in_0.SResp = (!fifo_empty && !head_tag) ? out.SResp : NULL;
  assign in_1.SResp = (!fifo_empty &&  head_tag) ? out.SResp : NULL;
  assign in_0.SData = (!fifo_empty && !head_tag) ? out.SData : '0;
  assign in_1.SData = (!fifo_empty &&  head_tag) ? out.SData : '0;

  assign resp_acc        = !fifo_empty && (head_tag ? in_1.MRespAccept : in_0.MRespAccept);
  assign out.MRespAccept = resp_acc;
  assign tag_pop         = resp_acc && (out.SResp != NULL);

  bus_if_arb_tag_fifo #(
    .WIDTH (1),
    .DEPTH (NUM_IN_FLIGHT)
  ) u_tag_fifo (
    .clk      (Clk),
    .rst_n    (MReset_n),
    .push     (cmd_acc),
    .pop      (tag_pop),
    .data_in  (gnt_idx),
    .data_out (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_bus_if_arb.sv
// Directed self-checking bench for bus_if_arb (NUM_IN_FLIGHT = 4).
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
// Expected grant order on ties follows the build's tie-break mode.
module tb_bus_if_arb;
  import bus_if_arb_pkg::*;

  logic Clk;
  logic MReset_n;
  int   checks = 0;
  int   errors = 0;

  Bus_if b0 ();
  Bus_if b1 ();
  Bus_if bo ();

  bus_if_arb #(.NUM_IN_FLIGHT(4)) dut (
    .Clk      (Clk),
    .MReset_n (MReset_n),
    .in_0     (b0),
    .in_1     (b1),
    .out      (bo)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic all_idle;
    b0.MCmd = IDLE;  b1.MCmd = IDLE;
    b0.MRespAccept = 1'b0; b1.MRespAccept = 1'b0;
    bo.SCmdAccept = 1'b0; bo.SDataAccept = 1'b0;
    bo.SResp = NULL; bo.SData = '0;
  endtask

  logic exp_g [3];

  initial begin
`ifdef BUS_IF_ARB_FIXED_PRIO_EN
    exp_g[0] = 1'b0; exp_g[1] = 1'b0; exp_g[2] = 1'b0;
`else
    exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0;
`endif
    // ---------------- reset: requests and accepts present but must be masked
    MReset_n = 1'b0;
    b0.MReset_n = 1'b1; b1.MReset_n = 1'b1;
    all_idle();
    b0.MCmd = WR; b0.MAddr = 32'h10; b0.MData = 32'hD0; b0.MDataValid = 1'b1; b0.MByteEn = 4'hF;
    b1.MCmd = RD; b1.MAddr = 32'h20; b1.MData = 32'hD1; b1.MDataValid = 1'b1; b1.MByteEn = 4'h3;
    bo.SCmdAccept = 1'b1; bo.SDataAccept = 1'b1;
    b0.MRespAccept = 1'b1; b1.MRespAccept = 1'b1;
    bo.SResp = DVA; bo.SData = 32'h99;
    #3;
    chk("rst_mcmd",     bo.MCmd, IDLE);
    chk("rst_cacc0",    b0.SCmdAccept, 1'b0);
    chk("rst_cacc1",    b1.SCmdAccept, 1'b0);
    chk("rst_dacc0",    b0.SDataAccept, 1'b0);
    chk("rst_respacc",  bo.MRespAccept, 1'b0);
    chk("rst_sresp0",   b0.SResp, NULL);
    chk("rst_sresp1",   b1.SResp, NULL);
    chk("rst_fwd",      bo.MReset_n, 1'b0);
    tick(); tick();
    chk("rst_state",    dut.state_q, ARB_FREE);
    chk("rst_cnt",      dut.u_tag_fifo.cnt_q, 0);
    all_idle();
    MReset_n = 1'b1;

    // ---------------- tie: both WR every cycle, slave accepts every cycle
    for (int k = 0; k < 3; k++) begin
      tick();
      b0.MCmd = WR; b1.MCmd = WR;
      bo.SCmdAccept = 1'b1; bo.SDataAccept = 1'b1;
      #1;
      chk("tie_mcmd",  bo.MCmd, WR);
      chk("tie_addr",  bo.MAddr, exp_g[k] ? 32'h20 : 32'h10);
      chk("tie_data",  bo.MData, exp_g[k] ? 32'hD1 : 32'hD0);
      chk("tie_be",    bo.MByteEn, exp_g[k] ? 4'h3 : 4'hF);
      chk("tie_cacc0", b0.SCmdAccept, !exp_g[k]);
      chk("tie_cacc1", b1.SCmdAccept, exp_g[k]);
      chk("tie_dacc0", b0.SDataAccept, !exp_g[k]);
    end
    tick();
    all_idle();
    #1;
    chk("tie_idle",  bo.MCmd, IDLE);
    chk("tie_cnt",   dut.u_tag_fifo.cnt_q, 3);
    for (int k = 0; k < 3; k++) begin
      bo.SResp = DVA; bo.SData = 32'h50 + k;
      b0.MRespAccept = 1'b1; b1.MRespAccept = 1'b1;
      #1;
      chk("drain_data",  exp_g[k] ? b1.SData : b0.SData, 32'h50 + k);
      chk("drain_other", exp_g[k] ? b0.SResp : b1.SResp, NULL);
      chk("drain_racc",  bo.MRespAccept, 1'b1);
      tick();
    end
    all_idle();
    #1;
    chk("drain_cnt",  dut.u_tag_fifo.cnt_q, 0);
    chk("drain_racc0", bo.MRespAccept, 1'b0);

    // ---------------- hold: in_1 RD not accepted for 3 cycles, in_0 also asks
    tick();
    b1.MCmd = RD; b1.MAddr = 32'h100;
    #1;
    chk("hold_c1_addr",  bo.MAddr, 32'h100);
    chk("hold_c1_cacc1", b1.SCmdAccept, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      b0.MCmd = RD; b0.MAddr = 32'h200;
      bo.SCmdAccept = (i == 2);
      #1;
      chk("hold_state", dut.state_q, ARB_HOLD_1);
      chk("hold_addr",  bo.MAddr, 32'h100);
      chk("hold_cacc0", b0.SCmdAccept, 1'b0);
      chk("hold_cacc1", b1.SCmdAccept, i == 2);
    end
    tick();
    b1.MCmd = IDLE;
    #1;
    chk("hold_free",  dut.state_q, ARB_FREE);
    chk("hold_next",  bo.MAddr, 32'h200);
    chk("hold_nacc0", b0.SCmdAccept, 1'b1);
    tick();
    all_idle();
    #1;
    chk("hold_cnt", dut.u_tag_fifo.cnt_q, 2);
    tick();
    bo.SResp = DVA; bo.SData = 32'h33; b0.MRespAccept = 1'b1; b1.MRespAccept = 1'b1;
    #1;
    chk("hold_r1", b1.SData, 32'h33);
    chk("hold_r1o", b0.SResp, NULL);
    tick();
    bo.SData = 32'h44;
    #1;
    chk("hold_r0", b0.SData, 32'h44);
    chk("hold_r0o", b1.SResp, NULL);
    tick();
    all_idle();
    #1;
    chk("hold_cnt0", dut.u_tag_fifo.cnt_q, 0);

    // ---------------- ordering: in_0 RD A then in_1 RD B; DVA 0x11 then 0x22
    tick();
    b0.MCmd = RD; b0.MAddr = 32'h300; bo.SCmdAccept = 1'b1;
    #1;
    chk("ord_acc0", b0.SCmdAccept, 1'b1);
    tick();
    b0.MCmd = IDLE; b1.MCmd = RD; b1.MAddr = 32'h400;
    #1;
    chk("ord_acc1",  b1.SCmdAccept, 1'b1);
    chk("ord_addr1", bo.MAddr, 32'h400);
    tick();
    b1.MCmd = IDLE; bo.SCmdAccept = 1'b0;
    bo.SResp = DVA; bo.SData = 32'h11; b0.MRespAccept = 1'b1; b1.MRespAccept = 1'b1;
    #1;
    chk("ord_d0",   b0.SData, 32'h11);
    chk("ord_r0",   b0.SResp, DVA);
    chk("ord_r1n",  b1.SResp, NULL);
    chk("ord_d1z",  b1.SData, 32'h0);
    tick();
    bo.SData = 32'h22;
    #1;
    chk("ord_d1",   b1.SData, 32'h22);
    chk("ord_r0n",  b0.SResp, NULL);
    tick();
    all_idle();
    #1;
    chk("ord_cnt",  dut.u_tag_fifo.cnt_q, 0);
    chk("ord_racc", bo.MRespAccept, 1'b0);

    // ---------------- full: 4 reads outstanding, 5th waits for a pop
    for (int k = 0; k < 4; k++) begin
      tick();
      b0.MCmd = RD; b0.MAddr = 32'h500 + k; bo.SCmdAccept = 1'b1;
      #1;
      chk("full_fill", b0.SCmdAccept, 1'b1);
    end
    tick();
    b0.MCmd = IDLE; b1.MCmd = RD; b1.MAddr = 32'h600;
    #1;
    chk("full_cnt",   dut.u_tag_fifo.cnt_q, 4);
    chk("full_idle1", bo.MCmd, IDLE);
    chk("full_cacc1", b1.SCmdAccept, 1'b0);
    tick();
    #1;
    chk("full_idle2", bo.MCmd, IDLE);
    tick();
    bo.SResp = DVA; bo.SData = 32'h77; b0.MRespAccept = 1'b1;
    #1;
    chk("full_popcyc", bo.MCmd, IDLE);
    chk("full_pdata",  b0.SData, 32'h77);
    tick();
    bo.SResp = NULL;
    #1;
    chk("full_cnt3",  dut.u_tag_fifo.cnt_q, 3);
    chk("full_gnt",   bo.MCmd, RD);
    chk("full_addr",  bo.MAddr, 32'h600);
    chk("full_acc5",  b1.SCmdAccept, 1'b1);
    tick();
    b1.MCmd = IDLE;
    #1;
    chk("full_cnt4",  dut.u_tag_fifo.cnt_q, 4);

    // ---------------- push/pop at occupancy 2 (tags now 0,0,0,1)
    tick();
    bo.SResp = DVA; bo.SData = 32'h81; b0.MRespAccept = 1'b1; b1.MRespAccept = 1'b1;
    #1;
    chk("pp_pre0", b0.SData, 32'h81);
    tick();
    bo.SData = 32'h82;
    #1;
    chk("pp_pre1", b0.SData, 32'h82);
    tick();
    bo.SResp = NULL;
    #1;
    chk("pp_cnt2", dut.u_tag_fifo.cnt_q, 2);
    tick();
    b0.MCmd = RD; b0.MAddr = 32'h700; bo.SCmdAccept = 1'b1;
    bo.SResp = DVA; bo.SData = 32'h83;
    #1;
    chk("pp_data", b0.SData, 32'h83);
    chk("pp_acc",  b0.SCmdAccept, 1'b1);
    tick();
    b0.MCmd = IDLE; bo.SResp = NULL;
    #1;
    chk("pp_cnt",  dut.u_tag_fifo.cnt_q, 2);
    tick();
    bo.SResp = DVA; bo.SData = 32'h84;
    #1;
    chk("pp_ord1", b1.SData, 32'h84);
    chk("pp_ord1o", b0.SResp, NULL);
    tick();
    bo.SData = 32'h85;
    #1;
    chk("pp_ord0", b0.SData, 32'h85);
    tick();
    all_idle();
    #1;
    chk("pp_cnt0", dut.u_tag_fifo.cnt_q, 0);

    // ---------------- reset with 2 tags outstanding and a hold active
    tick();
    b1.MCmd = RD; b1.MAddr = 32'h800; bo.SCmdAccept = 1'b1;
    #1;
    tick();
    b1.MCmd = IDLE; b0.MCmd = RD; b0.MAddr = 32'h900;
    #1;
    tick();
    b0.MCmd = IDLE; b1.MCmd = RD; b1.MAddr = 32'h990; bo.SCmdAccept = 1'b0;
    #1;
    chk("rr_cnt2", dut.u_tag_fifo.cnt_q, 2);
    tick();
    #1;
    chk("rr_hold", dut.state_q, ARB_HOLD_1);
    MReset_n = 1'b0; bo.SCmdAccept = 1'b1;
    #1;
    chk("rr_cnt0",  dut.u_tag_fifo.cnt_q, 0);
    chk("rr_state", dut.state_q, ARB_FREE);
    chk("rr_mcmd",  bo.MCmd, IDLE);
    chk("rr_cacc1", b1.SCmdAccept, 1'b0);
    b1.MCmd = IDLE;
    tick();
    MReset_n = 1'b1;
    tick();
    b0.MCmd = WR; b0.MAddr = 32'hA00; b1.MCmd = WR; b1.MAddr = 32'hB00;
    #1;
    chk("rr_tie0",  b0.SCmdAccept, 1'b1);
    chk("rr_tie1",  b1.SCmdAccept, 1'b0);
    chk("rr_addr",  bo.MAddr, 32'hA00);
    tick();
    all_idle();
    #1;
    chk("rr_cnt1",  dut.u_tag_fifo.cnt_q, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
